// File: rtl/bram_arbiter.sv
// Two-master Wishbone arbiter in front of the block RAM data port.
// One transaction in flight at a time, round-robin grant, watchdog error termination.
module bram_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_m0_stb,
    input  logic            i_m0_we,
    input  logic [2:0]      i_m0_sel,
    input  logic [XLEN-1:0] i_m0_addr,
    input  logic [XLEN-1:0] i_m0_data,
    output logic [XLEN-1:0] o_m0_data,
    output logic            o_m0_stall,
    output logic            o_m0_ack,
    output logic            o_m0_err,
    input  logic            i_m1_stb,
    input  logic            i_m1_we,
    input  logic [2:0]      i_m1_sel,
    input  logic [XLEN-1:0] i_m1_addr,
    input  logic [XLEN-1:0] i_m1_data,
    output logic [XLEN-1:0] o_m1_data,
    output logic            o_m1_stall,
    output logic            o_m1_ack,
    output logic            o_m1_err,
    output logic            o_s_stb,
    output logic            o_s_we,
    output logic [2:0]      o_s_sel,
    output logic [XLEN-1:0] o_s_addr,
    output logic [XLEN-1:0] o_s_data,
    input  logic [XLEN-1:0] i_s_data,
    input  logic            i_s_stall,
    input  logic            i_s_ack,
    output logic            o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_next;
    logic          grant;
    logic          last_grant;
    logic [TW-1:0] count;
    logic          acc0, acc1;
    logic          ack_hit, timeout_hit;

    // Acceptance is combinational so the winner sees stall low in the same cycle.
    always_comb begin
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (state == IDLE) begin
            if (i_m0_stb && i_m1_stb) begin
                if (last_grant) acc0 = 1'b1;
                else            acc1 = 1'b1;
            end else if (i_m0_stb) begin
                acc0 = 1'b1;
            end else if (i_m1_stb) begin
                acc1 = 1'b1;
            end
        end
    end

    assign ack_hit     = (state == WAIT) && i_s_ack;
    assign timeout_hit = (state == WAIT) && (count >= TW'(TIMEOUT));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (acc0 || acc1) state_next = ISSUE;
            ISSUE:   if (!i_s_stall) state_next = WAIT;
            WAIT:    if (ack_hit || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            count      <= '0;
            o_s_stb    <= 1'b0;
            o_s_we     <= 1'b0;
            o_s_sel    <= '0;
            o_s_addr   <= '0;
            o_s_data   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        o_s_stb    <= 1'b1;
                        o_s_we     <= acc1 ? i_m1_we   : i_m0_we;
                        o_s_sel    <= acc1 ? i_m1_sel  : i_m0_sel;
                        o_s_addr   <= acc1 ? i_m1_addr : i_m0_addr;
                        o_s_data   <= acc1 ? i_m1_data : i_m0_data;
                        grant      <= acc1;
                        last_grant <= acc1;
                    end
                end
                ISSUE: begin
                    if (!i_s_stall) begin
                        o_s_stb <= 1'b0;
                        count   <= '0;
                    end
                end
                WAIT: begin
                    // Saturate rather than wrap so a stuck slave can never alias back to zero.
                    if (count != {TW{1'b1}}) count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_m0_stall = i_reset || !acc0;
    assign o_m1_stall = i_reset || !acc1;
    assign o_m0_ack   = ack_hit && !grant;
    assign o_m1_ack   = ack_hit && grant;
    assign o_m0_err   = timeout_hit && !i_s_ack && !grant;
    assign o_m1_err   = timeout_hit && !i_s_ack && grant;
    assign o_m0_data  = o_m0_ack ? i_s_data : '0;
    assign o_m1_data  = o_m1_ack ? i_s_data : '0;
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_stb, m0_we, m1_stb, m1_we;
    logic [2:0]  m0_sel, m1_sel;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
    logic        s_stb, s_we;
    logic [2:0]  s_sel;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_stall, s_ack, busy;

    int checks   = 0;
    int failures = 0;
    int last;
    logic [31:0] f_addr[2];
    logic [31:0] f_data[2];
    logic        f_we[2];
    logic [2:0]  f_sel[2];

    always #5 clk = ~clk;

    bram_arbiter #(.XLEN(32), .TIMEOUT(8), .TW(8)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_sel(m0_sel), .i_m0_addr(m0_addr),
        .i_m0_data(m0_wdata), .o_m0_data(m0_rdata), .o_m0_stall(m0_stall),
        .o_m0_ack(m0_ack), .o_m0_err(m0_err),
        .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_sel(m1_sel), .i_m1_addr(m1_addr),
        .i_m1_data(m1_wdata), .o_m1_data(m1_rdata), .o_m1_stall(m1_stall),
        .o_m1_ack(m1_ack), .o_m1_err(m1_err),
        .o_s_stb(s_stb), .o_s_we(s_we), .o_s_sel(s_sel), .o_s_addr(s_addr),
        .o_s_data(s_wdata), .i_s_data(s_rdata), .i_s_stall(s_stall), .i_s_ack(s_ack),
        .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [31:0] ack_of(input int m);
        return (m == 1) ? 32'(m1_ack) : 32'(m0_ack);
    endfunction

    function automatic logic [31:0] data_of(input int m);
        return (m == 1) ? m1_rdata : m0_rdata;
    endfunction

    task automatic set_req(input int m, input logic on);
        if (m == 0) begin
            m0_stb = on; m0_we = f_we[0]; m0_sel = f_sel[0]; m0_addr = f_addr[0]; m0_wdata = f_data[0];
        end else begin
            m1_stb = on; m1_we = f_we[1]; m1_sel = f_sel[1]; m1_addr = f_addr[1]; m1_wdata = f_data[1];
        end
    endtask

    task automatic randomize_fields(input int m);
        f_addr[m] = $urandom;
        f_data[m] = $urandom;
        f_we[m]   = 1'($urandom_range(0, 1));
        f_sel[m]  = 3'($urandom_range(0, 7));
    endtask

    task automatic do_reset();
        rst = 1'b1; m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0; s_stall = 1'b0;
        last = 1;
        mid();
        chk("rst_m0_stall", m0_stall, 1);
        chk("rst_m1_stall", m1_stall, 1);
        chk("rst_busy", busy, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_data", s_wdata, 0);
        chk("rst_s_we_sel", {s_we, s_sel}, 0);
        chk("rst_acks_errs", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk("rst_mdata", m0_rdata | m1_rdata, 0);
        drive_edge();
        rst = 1'b0;
        drive_edge();
    endtask

    // One complete transaction: k slave-stall cycles in ISSUE, ack in WAIT cycle d.
    task automatic txn(input logic r0, input logic r1, input int k, input int d,
                       input logic [31:0] rdata, input logic spur);
        int w;
        w = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
        set_req(0, r0);
        set_req(1, r1);
        s_stall = 1'b0;
        s_ack   = 1'b0;
        mid();
        chk("accept_m0_stall", m0_stall, 32'(w != 0));
        chk("accept_m1_stall", m1_stall, 32'(w != 1));
        chk("accept_busy", busy, 0);
        chk("accept_s_stb", s_stb, 0);
        last = w;
        drive_edge();
        set_req(w, 1'b0);
        s_stall = (k > 0);
        if (spur) begin
            s_ack   = 1'b1;
            s_rdata = $urandom;
        end
        for (int j = 0; j <= k; j++) begin
            mid();
            chk("issue_s_stb", s_stb, 1);
            chk("issue_s_addr", s_addr, f_addr[w]);
            chk("issue_s_data", s_wdata, f_data[w]);
            chk("issue_s_we_sel", {s_we, s_sel}, {f_we[w], f_sel[w]});
            chk("issue_stalls", {m0_stall, m1_stall}, 2'b11);
            chk("issue_no_ack", {m0_ack, m1_ack}, 0);
            chk("issue_no_data", m0_rdata | m1_rdata, 0);
            drive_edge();
            s_stall = (j + 1 < k);
        end
        s_ack = 1'b0;
        for (int v = 0; v <= d; v++) begin
            if (v == d) begin
                s_ack   = 1'b1;
                s_rdata = rdata;
            end
            mid();
            chk("wait_s_stb", s_stb, 0);
            chk("wait_busy", busy, 1);
            chk("wait_no_err", {m0_err, m1_err}, 0);
            chk("wait_stalls", {m0_stall, m1_stall}, 2'b11);
            if (v == d) begin
                chk("ack_granted", ack_of(w), 1);
                chk("data_granted", data_of(w), rdata);
                chk("ack_other", ack_of(1 - w), 0);
                chk("data_other", data_of(1 - w), 0);
            end else begin
                chk("wait_no_ack", {m0_ack, m1_ack}, 0);
            end
            drive_edge();
        end
        s_ack = 1'b0;
    endtask

    initial begin
        logic r0, r1;
        rst = 1'b1; s_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            f_addr[m] = '0; f_data[m] = '0; f_we[m] = 1'b0; f_sel[m] = '0;
        end
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        s_stall = 1'b0; s_ack = 1'b0;
        drive_edge();
        do_reset();

        // m0 write, zero-stall slave, ack in the first WAIT cycle
        f_addr[0] = 32'h10; f_data[0] = 32'hDEADBEEF; f_we[0] = 1'b1; f_sel[0] = 3'b111;
        txn(1'b1, 1'b0, 0, 0, 32'h0000_00A5, 1'b0);
        mid();
        chk("post_txn_idle", busy, 0);
        drive_edge();

        // continuous contention after reset: m0,m1,m0,m1
        do_reset();
        randomize_fields(0);
        randomize_fields(1);
        for (int i = 0; i < 4; i++) txn(1'b1, 1'b1, 0, 0, $urandom, 1'b0);

        // m1 read of 0x40
        f_addr[1] = 32'h40; f_we[1] = 1'b0; f_sel[1] = 3'b010;
        txn(1'b0, 1'b1, 0, 0, 32'h12345678, 1'b0);

        // slave stalls 3 cycles in ISSUE, spurious ack there must be ignored
        randomize_fields(0);
        txn(1'b1, 1'b0, 3, 1, $urandom, 1'b1);

        // ack on the very cycle the watchdog expires: ack wins
        randomize_fields(1);
        txn(1'b0, 1'b1, 0, 8, $urandom, 1'b0);

        // watchdog timeout on m0 while m1 waits
        randomize_fields(0);
        randomize_fields(1);
        set_req(0, 1'b1);
        set_req(1, 1'b0);
        mid();
        chk("to_accept_m0", m0_stall, 0);
        last = 0;
        drive_edge();
        set_req(0, 1'b0);
        set_req(1, 1'b1);
        mid();
        chk("to_issue", s_stb, 1);
        drive_edge();
        for (int v = 0; v < 8; v++) begin
            mid();
            chk("to_no_err_yet", {m0_err, m1_err, m0_ack}, 0);
            chk("to_m1_stalled", m1_stall, 1);
            drive_edge();
        end
        mid();
        chk("to_m0_err", m0_err, 1);
        chk("to_no_ack_m1err", {m0_ack, m1_ack, m1_err}, 0);
        chk("to_busy", busy, 1);
        drive_edge();
        txn(1'b0, 1'b1, 0, 0, $urandom, 1'b0);
        mid();
        chk("to_err_single", m0_err, 0);
        drive_edge();

        // reset during WAIT, late ack afterwards
        randomize_fields(1);
        set_req(0, 1'b0);
        set_req(1, 1'b1);
        mid();
        chk("rw_accept_m1", m1_stall, 0);
        drive_edge();
        set_req(1, 1'b0);
        mid();
        drive_edge();
        mid();
        chk("rw_in_wait", busy, 1);
        drive_edge();
        do_reset();
        mid();
        chk("rw_idle", busy, 0);
        drive_edge();
        s_ack = 1'b1; s_rdata = 32'hCAFEF00D;
        mid();
        chk("rw_late_ack", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk("rw_late_data", m0_rdata | m1_rdata, 0);
        chk("rw_still_idle", busy, 0);
        drive_edge();
        s_ack = 1'b0;
        randomize_fields(0);
        randomize_fields(1);
        txn(1'b1, 1'b1, 0, 0, $urandom, 1'b0);

        // randomized traffic; a stalled requester keeps its request and fields
        for (int n = 0; n < 40; n++) begin
            r0 = m0_stb;
            r1 = m1_stb;
            if (!r0) begin r0 = 1'($urandom_range(0, 1)); randomize_fields(0); end
            if (!r1) begin r1 = 1'($urandom_range(0, 1)); randomize_fields(1); end
            if (!r0 && !r1) r0 = 1'b1;
            txn(r0, r1, $urandom_range(0, 3), $urandom_range(0, 7), $urandom,
                1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
Two-master, one-slave Wishbone arbiter sharing the FPGA block RAM data port between the hart (master 0) and a loader/DMA requester (master 1).
- Sits between the requesters and block_ram.
- Allows one outstanding transaction at a time, granted round-robin.
- A watchdog terminates hung transactions with an error pulse to the granted master.

Parameters:
- XLEN, 32, address and data width.
- TIMEOUT, 255, maximum cycles spent in WAIT before an error termination (must be ≥1).
- TW, 8, watchdog counter width (2^TW > TIMEOUT).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_m0_stb / i_m1_stb  in  1  request strobe per master.
- i_m0_we / i_m1_we  in  1  write enable.
- i_m0_sel / i_m1_sel  in  3  access select, forwarded unchanged.
- i_m0_addr / i_m1_addr  in  XLEN  byte address.
- i_m0_data / i_m1_data  in  XLEN  write data.
- o_m0_data / o_m1_data  out  XLEN  read data, valid with ack.
- o_m0_stall / o_m1_stall  out  1  request not accepted this cycle.
- o_m0_ack / o_m1_ack  out  1  transaction complete, one-cycle pulse.
- o_m0_err / o_m1_err  out  1  watchdog termination, one-cycle pulse.
- o_s_stb, o_s_we  out  1  slave strobe and write enable.
- o_s_sel  out  3  slave select.
- o_s_addr, o_s_data  out  XLEN  slave address and write data.
- i_s_data  in  XLEN  slave read data.
- i_s_stall, i_s_ack  in  1  slave stall and ack.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async, i_reset=1):
  - State IDLE; last_grant=1, so m0 wins the first tie.
  - Watchdog counter 0.
  - All o_s_* 0; all ack/err 0; o_busy 0; o_mX_data 0.
  - Both o_mX_stall 1 while reset is asserted.
- States:
  - IDLE: a master's stall is low only in the cycle it is accepted. Accept rules:
    - Only one stb high: accept that master.
    - Both stb high: accept the master != last_grant.
    - On accept: latch we/sel/addr/data into the o_s_* registers, set grant and last_grant, go to ISSUE.
    - The non-accepted master sees stall=1 and must hold its request stable.
  - ISSUE: o_s_stb=1, fields held constant. When i_s_stall=0, o_s_stb drops next cycle and the state goes to WAIT with counter=0.
  - WAIT:
    - Counter increments each cycle.
    - i_s_ack=1: o_m[grant]_ack=1 combinationally that cycle and o_m[grant]_data=i_s_data; next state IDLE.
    - Counter reaches TIMEOUT without ack: o_m[grant]_err=1 for one cycle; next state IDLE.
    - Ack in the same cycle as the timeout: ack wins, no err.
- Both masters stall=1 in ISSUE and WAIT.
- Non-granted master: ack, err and data are always 0.
- i_s_ack outside WAIT is ignored and never routed.
- Latency with a zero-stall slave and 1-cycle ack:
  - Accept at cycle 0, o_s_stb at cycle 1, master ack at cycle 2.
  - Next accept possible at cycle 3.
- A master dropping stb while stalled withdraws its request; no ordering is guaranteed to it.
- Round robin gives starvation-free alternation under continuous contention.
- Reset mid-transaction: immediate return to IDLE and outputs cleared. The in-flight transaction is dropped; a late i_s_ack after reset release is ignored because the state is IDLE.
- Width rules: addresses are passed through unmodified, with no alignment check in this block. The counter saturates, never wraps.

Test Plan:
- m0 write addr 0x10 data 0xDEADBEEF sel 3'b111, slave stall=0, ack 1 cycle after accept -> o_s_stb high exactly cycle 1 with addr 0x10/data 0xDEADBEEF/we=1; o_m0_ack pulse cycle 2; o_m1_ack/err never high.
- Both masters hold stb continuously after reset, 4 transactions -> grant order m0,m1,m0,m1; each non-granted master's stall stays 1 until its accept cycle.
- m1 read addr 0x40, slave returns i_s_data=0x12345678 with ack -> o_m1_data=0x12345678 and o_m1_ack=1 same cycle; o_m0_ack=0, o_m0_data=0.
- i_s_stall=1 for 3 cycles during ISSUE -> o_s_stb high 4 consecutive cycles with addr/data/sel/we unchanged; WAIT entered after the stall drops.
- TIMEOUT=8, slave never acks -> o_m0_err single pulse 8 cycles into WAIT, no ack, o_busy falls the next cycle, m1 accepted next if requesting.
- i_reset pulsed during WAIT, slave asserts ack 2 cycles after reset release -> all outputs 0 during reset, no o_mX_ack afterwards, state IDLE, next tie goes to m0.
